// File: rtl/button_strobe_gen.sv
// -----------------------------------------------------------------------------
// button_strobe_gen
//
// Turns raw, asynchronous, active-high push-buttons into clean single-cycle
// command strobes. Each channel is synchronized (two flops), debounced (level
// accepted after DEBOUNCE_CYCLES consecutive disagreeing samples), edge
// detected, and optionally auto-repeated while held.
//
// Ports
//   clock_i     system clock
//   reset_n_i   asynchronous, active-low reset
//   btn_raw_i   raw button pins, 1 = pressed, asynchronous to clock_i
//   level_o     debounced button state
//   press_o     one-cycle pulse on each accepted 0->1 of level_o
//   release_o   one-cycle pulse on each accepted 1->0 of level_o
//   strobe_o    one-cycle command pulse: press OR auto-repeat
// -----------------------------------------------------------------------------
module button_strobe_gen #(
  parameter int unsigned        NUM_BTN         = 3,
  parameter int unsigned        DEBOUNCE_CYCLES = 120000,
  parameter int unsigned        REPEAT_DELAY    = 6000000,
  parameter int unsigned        REPEAT_PERIOD   = 1200000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = '0
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] strobe_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_MX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = $clog2(RPT_MX);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } rpt_state_e;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            rise_d, fall_d;
    logic            press_q, release_q, strobe_q;
    rpt_state_e      state_q, state_d;
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
    logic            rpt_d;

    // NOTE: every flop here, counters included, is async-reset so that a reset
    // at any moment discards debounce and repeat progress and silences outputs.
    // NOTE: sequential state uses non-blocking assignments so that s2_q samples
    // the old s1_q, giving a true two-stage synchronizer.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        level_q   <= 1'b0;
        db_cnt_q  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        strobe_q  <= 1'b0;
        state_q   <= ST_IDLE;
        rp_cnt_q  <= '0;
      end else begin
        s1_q      <= btn_raw_i[i];
        s2_q      <= s1_q;
        level_q   <= level_d;
        db_cnt_q  <= db_cnt_d;
        press_q   <= rise_d;
        release_q <= fall_d;
        strobe_q  <= rise_d | rpt_d;
        state_q   <= state_d;
        rp_cnt_q  <= rp_cnt_d;
      end
    end

    // Debounce: count consecutive samples where s2 disagrees with the accepted
    // level; any agreeing sample (a bounce) restarts the count from zero.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (s2_q != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = s2_q;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    // Repeat FSM. It reacts to the same-edge press event, so the counter holds
    // k in the k-th cycle after the press strobe and the repeat pulse lands
    // exactly REPEAT_DELAY cycles after it.
    always_comb begin
      state_d  = state_q;
      rp_cnt_d = rp_cnt_q;
      rpt_d    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise_d && REPEAT_MASK[i]) begin
            state_d  = ST_HELD;
            rp_cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (rp_cnt_q == DLY_LAST) begin
            rpt_d    = 1'b1;
            rp_cnt_d = '0;
            state_d  = ST_REPEAT;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (rp_cnt_q == PER_LAST) begin
            rpt_d    = 1'b1;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          rp_cnt_d = '0;
        end
      endcase
      // Release wins over everything, including a repeat due on the same edge.
      if (fall_d) begin
        state_d  = ST_IDLE;
        rp_cnt_d = '0;
        rpt_d    = 1'b0;
      end
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign strobe_o[i]  = strobe_q;
  end

endmodule
